// File: rtl/axi_sram_slave.sv
// AXI3 slave backed by a 32-bit word SRAM; independent read and write burst engines.
// Define AXI_SRAM_SLAVE_WRAP_EN to support WRAP bursts; otherwise they complete with SLVERR.
module axi_sram_slave #(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic        i_clock,
  input  logic        i_reset,
  // Read address channel
  input  logic [3:0]  i_arid,
  input  logic [31:0] i_araddr,
  input  logic [7:0]  i_arlen,
  input  logic [2:0]  i_arsize,
  input  logic [1:0]  i_arburst,
  input  logic [1:0]  i_arlock,
  input  logic [3:0]  i_arcache,
  input  logic [2:0]  i_arprot,
  input  logic        i_arvalid,
  output logic        o_arready,
  // Read data channel
  output logic [3:0]  o_rid,
  output logic [31:0] o_rdata,
  output logic [1:0]  o_rresp,
  output logic        o_rlast,
  output logic        o_rvalid,
  input  logic        i_rready,
  // Write address channel
  input  logic [3:0]  i_awid,
  input  logic [31:0] i_awaddr,
  input  logic [7:0]  i_awlen,
  input  logic [2:0]  i_awsize,
  input  logic [1:0]  i_awburst,
  input  logic [1:0]  i_awlock,
  input  logic [3:0]  i_awcache,
  input  logic [2:0]  i_awprot,
  input  logic        i_awvalid,
  output logic        o_awready,
  // Write data channel
  input  logic [3:0]  i_wid,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  input  logic        i_wlast,
  input  logic        i_wvalid,
  output logic        o_wready,
  // Write response channel
  output logic [3:0]  o_bid,
  output logic [1:0]  o_bresp,
  output logic        o_bvalid,
  input  logic        i_bready
);

  localparam int unsigned Words = 2 ** (ADDR_WIDTH - 2);
  localparam logic [1:0] BurstFixed = 2'd0;
  localparam logic [1:0] BurstWrap  = 2'd2;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

`ifdef AXI_SRAM_SLAVE_WRAP_EN
  localparam bit WrapEn = 1'b1;
`else
  localparam bit WrapEn = 1'b0;
`endif

  typedef enum logic {RIdle, RBurst} rstate_e;
  typedef enum logic [1:0] {WIdle, WData, WResp} wstate_e;

  logic [31:0] r_mem [Words];

  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] incr;
    logic [31:0] wmask;
    incr  = 32'd1 << size;
    wmask = (({24'd0, len} + 32'd1) << size) - 32'd1;
    case (burst)
      BurstFixed: next_addr = addr;
      BurstWrap:  next_addr = WrapEn ? ((addr & ~wmask) | ((addr + incr) & wmask)) : addr;
      default:    next_addr = addr + incr;
    endcase
  endfunction

  // Handshakes stay low until the first clock edge after reset is released.
  logic r_ready_en;
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_ready_en <= 1'b0;
    else         r_ready_en <= 1'b1;
  end

  logic w_unused;
  assign w_unused = ^{i_arlock, i_arcache, i_arprot, i_awlock, i_awcache, i_awprot, i_wid};

  // ---------------------------------------------------------------- read engine
  rstate_e     r_rstate, w_rstate_next;
  logic [31:0] r_raddr, w_rd_addr;
  logic [7:0]  r_rlen, r_rbeat;
  logic [2:0]  r_rsize;
  logic [1:0]  r_rburst, r_rresp;
  logic [3:0]  r_rid;
  logic [31:0] r_rdata;
  logic        r_rlast, r_rerr;
  logic        w_arready, w_ar_err, w_rd_load, w_rd_first, w_rd_err;

  assign w_arready = (r_rstate == RIdle) && r_ready_en;
  assign w_ar_err  = (i_arburst == BurstWrap) && !WrapEn;

  always_comb begin
    w_rstate_next = r_rstate;
    w_rd_load     = 1'b0;
    w_rd_first    = 1'b0;
    w_rd_addr     = r_raddr;
    w_rd_err      = r_rerr;
    unique case (r_rstate)
      RIdle: begin
        if (w_arready && i_arvalid) begin
          w_rstate_next = RBurst;
          w_rd_load     = 1'b1;
          w_rd_first    = 1'b1;
          w_rd_addr     = i_araddr;
          w_rd_err      = w_ar_err;
        end
      end
      RBurst: begin
        if (i_rready) begin
          if (r_rlast) begin
            w_rstate_next = RIdle;
          end else begin
            w_rd_load = 1'b1;
            w_rd_addr = next_addr(r_raddr, r_rlen, r_rsize, r_rburst);
          end
        end
      end
      default: w_rstate_next = RIdle;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_rstate <= RIdle;
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rbeat  <= '0;
      r_rsize  <= '0;
      r_rburst <= '0;
      r_rresp  <= '0;
      r_rid    <= '0;
      r_rdata  <= '0;
      r_rlast  <= 1'b0;
      r_rerr   <= 1'b0;
    end else begin
      r_rstate <= w_rstate_next;
      if (w_rd_first) begin
        r_rlen   <= i_arlen;
        r_rsize  <= i_arsize;
        r_rburst <= i_arburst;
        r_rid    <= i_arid;
        r_rerr   <= w_ar_err;
        r_rbeat  <= '0;
        r_rlast  <= (i_arlen == 8'd0);
      end else if (w_rd_load) begin
        r_rbeat <= r_rbeat + 8'd1;
        r_rlast <= ((r_rbeat + 8'd1) == r_rlen);
      end else if (w_rstate_next == RIdle) begin
        r_rlast <= 1'b0;
      end
      if (w_rd_load) begin
        r_raddr <= w_rd_addr;
        r_rdata <= w_rd_err ? '0 : r_mem[w_rd_addr[ADDR_WIDTH-1:2]];
        r_rresp <= w_rd_err ? RespSlvErr : RespOkay;
      end
    end
  end

  assign o_arready = w_arready;
  assign o_rvalid  = (r_rstate == RBurst);
  assign o_rid     = r_rid;
  assign o_rdata   = r_rdata;
  assign o_rresp   = r_rresp;
  assign o_rlast   = r_rlast;

  // ---------------------------------------------------------------- write engine
  wstate_e     r_wstate, w_wstate_next;
  logic [31:0] r_waddr;
  logic [7:0]  r_wlen, r_wbeat;
  logic [2:0]  r_wsize;
  logic [1:0]  r_wburst;
  logic [3:0]  r_bid;
  logic        r_berr, r_wdrop;
  logic        w_awready, w_aw_err, w_aw_hs, w_w_hs, w_wlast_exp, w_mem_we;

  assign w_awready   = (r_wstate == WIdle) && r_ready_en;
  assign w_aw_err    = (i_awburst == BurstWrap) && !WrapEn;
  assign w_wlast_exp = (r_wbeat == r_wlen);

  always_comb begin
    w_wstate_next = r_wstate;
    w_aw_hs       = 1'b0;
    w_w_hs        = 1'b0;
    unique case (r_wstate)
      WIdle: begin
        if (w_awready && i_awvalid) begin
          w_wstate_next = WData;
          w_aw_hs       = 1'b1;
        end
      end
      WData: begin
        if (i_wvalid) begin
          w_w_hs = 1'b1;
          if (w_wlast_exp) w_wstate_next = WResp;
        end
      end
      WResp: begin
        if (i_bready) w_wstate_next = WIdle;
      end
      default: w_wstate_next = WIdle;
    endcase
  end

  assign w_mem_we = w_w_hs && !r_wdrop;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wstate <= WIdle;
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_wbeat  <= '0;
      r_wsize  <= '0;
      r_wburst <= '0;
      r_bid    <= '0;
      r_berr   <= 1'b0;
      r_wdrop  <= 1'b0;
    end else begin
      r_wstate <= w_wstate_next;
      if (w_aw_hs) begin
        r_waddr  <= i_awaddr;
        r_wlen   <= i_awlen;
        r_wsize  <= i_awsize;
        r_wburst <= i_awburst;
        r_bid    <= i_awid;
        r_wbeat  <= '0;
        r_berr   <= w_aw_err;
        r_wdrop  <= w_aw_err;
      end else if (w_w_hs) begin
        r_waddr <= next_addr(r_waddr, r_wlen, r_wsize, r_wburst);
        r_wbeat <= r_wbeat + 8'd1;
        // Early or missing wlast is flagged but the beat is still written.
        if (i_wlast != w_wlast_exp) r_berr <= 1'b1;
      end
    end
  end

  // The array is deliberately left out of reset so contents survive it.
  always_ff @(posedge i_clock) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wstrb[b]) r_mem[r_waddr[ADDR_WIDTH-1:2]][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_awready = w_awready;
  assign o_wready  = (r_wstate == WData);
  assign o_bvalid  = (r_wstate == WResp);
  assign o_bid     = r_bid;
  assign o_bresp   = r_berr ? RespSlvErr : RespOkay;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave; WRAP expectations follow
// AXI_SRAM_SLAVE_WRAP_EN.
module tb_axi_sram_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  arid = '0, awid = '0, wid = '0;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic [7:0]  arlen = '0, awlen = '0;
  logic [2:0]  arsize = 3'd2, awsize = 3'd2;
  logic [1:0]  arburst = 2'd1, awburst = 2'd1;
  logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
  logic        rready = 1'b0, bready = 1'b0;
  logic [3:0]  wstrb = '0;
  logic        arready, awready, rvalid, rlast, wready, bvalid;
  logic [3:0]  rid, bid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] wbuf [16];
  logic [31:0] rexp [16];

`ifdef AXI_SRAM_SLAVE_WRAP_EN
  localparam bit WrapEn = 1'b1;
`else
  localparam bit WrapEn = 1'b0;
`endif

  always #5 clk = ~clk;

  axi_sram_slave #(.ADDR_WIDTH(16)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_arid(arid), .i_araddr(araddr), .i_arlen(arlen), .i_arsize(arsize),
    .i_arburst(arburst), .i_arlock(2'b00), .i_arcache(4'h0), .i_arprot(3'b000),
    .i_arvalid(arvalid), .o_arready(arready),
    .o_rid(rid), .o_rdata(rdata), .o_rresp(rresp), .o_rlast(rlast), .o_rvalid(rvalid),
    .i_rready(rready),
    .i_awid(awid), .i_awaddr(awaddr), .i_awlen(awlen), .i_awsize(awsize),
    .i_awburst(awburst), .i_awlock(2'b00), .i_awcache(4'h0), .i_awprot(3'b000),
    .i_awvalid(awvalid), .o_awready(awready),
    .i_wid(wid), .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast), .i_wvalid(wvalid),
    .o_wready(wready),
    .o_bid(bid), .o_bresp(bresp), .o_bvalid(bvalid), .i_bready(bready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [3:0] strb, input int last_beat,
                          input logic [1:0] exp_resp, input int hold);
    int cnt;
    awaddr = addr; awlen = 8'(len); awburst = burst; awid = 4'h5; awvalid = 1'b1;
    cnt = 0;
    while (!awready && cnt < 50) begin tick(); cnt++; end
    if (cnt >= 50) check_eq("aw_timeout", 32'd0, 32'd1);
    tick();
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wdata = wbuf[i]; wstrb = strb; wlast = (i == last_beat); wvalid = 1'b1;
      cnt = 0;
      while (!wready && cnt < 50) begin tick(); cnt++; end
      if (cnt >= 50) check_eq("w_timeout", 32'd0, 32'd1);
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    check_eq("bvalid", bvalid, 1);
    check_eq("bresp", bresp, exp_resp);
    check_eq("bid", bid, 4'h5);
    for (int h = 0; h < hold; h++) begin
      tick();
      check_eq("bvalid_hold", bvalid, 1);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check_eq("bvalid_clr", bvalid, 0);
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                         input logic [3:0] id, input bit toggle, input logic [1:0] exp_resp);
    int cnt;
    araddr = addr; arlen = 8'(len); arburst = burst; arid = id; arvalid = 1'b1;
    cnt = 0;
    while (!arready && cnt < 50) begin tick(); cnt++; end
    if (cnt >= 50) check_eq("ar_timeout", 32'd0, 32'd1);
    tick();
    arvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (toggle) begin
        rready = 1'b0;
        tick();
        check_eq("r_stall_valid", rvalid, 1);
        check_eq("r_stall_data", rdata, rexp[i]);
        check_eq("r_stall_last", rlast, (i == len));
      end
      rready = 1'b1;
      check_eq("rvalid", rvalid, 1);
      check_eq("rdata", rdata, rexp[i]);
      check_eq("rresp", rresp, exp_resp);
      check_eq("rlast", rlast, (i == len));
      check_eq("rid", rid, id);
      tick();
    end
    rready = 1'b0;
    check_eq("rvalid_end", rvalid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_arready", arready, 0);
    check_eq("rst_awready", awready, 0);
    check_eq("rst_rvalid", rvalid, 0);
    check_eq("rst_wready", wready, 0);
    check_eq("rst_bvalid", bvalid, 0);
    check_eq("rst_rdata", rdata, 0);
    rst = 1'b0;
    tick();
    check_eq("post_rst_arready", arready, 1);
    check_eq("post_rst_awready", awready, 1);

    // INCR write then readback
    wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
    do_write(32'h100, 3, 2'd1, 4'hF, 3, 2'b00, 0);
    rexp[0] = 32'h11; rexp[1] = 32'h22; rexp[2] = 32'h33; rexp[3] = 32'h44;
    do_read(32'h100, 3, 2'd1, 4'h3, 1'b0, 2'b00);

    // Stalled read, rid 0xA
    do_read(32'h100, 3, 2'd1, 4'hA, 1'b1, 2'b00);

    // Byte strobes
    wbuf[0] = 32'h0;
    do_write(32'h0, 0, 2'd1, 4'hF, 0, 2'b00, 0);
    wbuf[0] = 32'hAABBCCDD;
    do_write(32'h0, 0, 2'd1, 4'b0101, 0, 2'b00, 0);
    rexp[0] = 32'h00BB00DD;
    do_read(32'h0, 0, 2'd1, 4'h1, 1'b0, 2'b00);

    // Early wlast: SLVERR, both beats still written, bvalid held
    wbuf[0] = 32'h55; wbuf[1] = 32'h66;
    do_write(32'h200, 1, 2'd1, 4'hF, 0, 2'b10, 3);
    rexp[0] = 32'h55; rexp[1] = 32'h66;
    do_read(32'h200, 1, 2'd1, 4'h2, 1'b0, 2'b00);

    // Missing wlast on the final beat
    wbuf[0] = 32'h12; wbuf[1] = 32'h34;
    do_write(32'h300, 1, 2'd1, 4'hF, 99, 2'b10, 0);
    rexp[0] = 32'h12; rexp[1] = 32'h34;
    do_read(32'h300, 1, 2'd1, 4'h2, 1'b0, 2'b00);

    // FIXED bursts hit one word
    wbuf[0] = 32'h77; wbuf[1] = 32'h88;
    do_write(32'h400, 1, 2'd0, 4'hF, 1, 2'b00, 0);
    rexp[0] = 32'h88; rexp[1] = 32'h88;
    do_read(32'h400, 1, 2'd0, 4'h4, 1'b0, 2'b00);

    // WRAP read 0x108 len 3: 0x108,0x10C,0x100,0x104
    if (WrapEn) begin
      rexp[0] = 32'h33; rexp[1] = 32'h44; rexp[2] = 32'h11; rexp[3] = 32'h22;
      do_read(32'h108, 3, 2'd2, 4'h6, 1'b0, 2'b00);
    end else begin
      rexp[0] = 32'h0; rexp[1] = 32'h0; rexp[2] = 32'h0; rexp[3] = 32'h0;
      do_read(32'h108, 3, 2'd2, 4'h6, 1'b0, 2'b10);
    end

    // WRAP write 0x504 len 1 wraps to 0x500, or is discarded
    wbuf[0] = 32'h1; wbuf[1] = 32'h2;
    do_write(32'h500, 1, 2'd1, 4'hF, 1, 2'b00, 0);
    wbuf[0] = 32'h99; wbuf[1] = 32'hAA;
    if (WrapEn) begin
      do_write(32'h504, 1, 2'd2, 4'hF, 1, 2'b00, 0);
      rexp[0] = 32'hAA; rexp[1] = 32'h99;
    end else begin
      do_write(32'h504, 1, 2'd2, 4'hF, 1, 2'b10, 0);
      rexp[0] = 32'h1; rexp[1] = 32'h2;
    end
    do_read(32'h500, 1, 2'd1, 4'h7, 1'b0, 2'b00);

    // Reset during beat 2 of an 8-beat read
    araddr = 32'h100; arlen = 8'd7; arburst = 2'd1; arid = 4'h9; arvalid = 1'b1;
    rready = 1'b1;
    tick();
    arvalid = 1'b0;
    check_eq("mid_b0", rdata, 32'h11);
    tick();
    check_eq("mid_b1", rdata, 32'h22);
    tick();
    check_eq("mid_b2", rdata, 32'h33);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_rvalid", rvalid, 0);
    check_eq("mid_rst_arready", arready, 0);
    check_eq("mid_rst_rlast", rlast, 0);
    check_eq("mid_rst_rdata", rdata, 0);
    rready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_eq("mid_post_arready", arready, 1);
    check_eq("mid_post_rvalid", rvalid, 0);
    rexp[0] = 32'h11; rexp[1] = 32'h22; rexp[2] = 32'h33; rexp[3] = 32'h44;
    do_read(32'h100, 3, 2'd1, 4'hB, 1'b0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 16: byte-address bits decoded; the array holds 2^(ADDR_WIDTH-2) 32-bit words.
REQ-002 clock  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 arid, awid  input  4  request IDs.
REQ-005 araddr, awaddr  input  32  byte start addresses; only bits [ADDR_WIDTH-1:2] index the array.
REQ-006 arlen, awlen  input  8  beats minus one; only values 0..15 are legal (AXI3).
REQ-007 arsize, awsize  input  3  beat size; the address increment is 1<<size.
REQ-008 arburst, awburst  input  2  burst type: 0 FIXED, 1 INCR, 2 WRAP.
REQ-009 arlock/arcache/arprot, awlock/awcache/awprot  input  2/4/3  accepted and ignored.
REQ-010 arvalid, awvalid  input  1; arready, awready  output  1  address-channel handshakes.
REQ-011 rid  output  4  equals the captured arid.
REQ-012 rdata  output  32  read data.
REQ-013 rresp  output  2  00 OKAY, 10 SLVERR.
REQ-014 rlast  output  1  marks the final beat.
REQ-015 rvalid  output  1; rready  input  1  read-data handshake.
REQ-016 wid  input  4  ignored; write interleaving is not supported.
REQ-017 wdata  input  32; wstrb  input  4  write data and byte enables.
REQ-018 wlast  input  1  master's last-beat marker.
REQ-019 wvalid  input  1; wready  output  1  write-data handshake.
REQ-020 bid  output  4; bresp  output  2  write response, with the same encoding as rresp.
REQ-021 bvalid  output  1; bready  input  1  write-response handshake.

Function
REQ-022 Read FSM: R_IDLE (arready=1) -> R_BURST on arvalid; R_BURST -> R_IDLE on the handshake of the beat with rlast=1.
REQ-023 Read latency: an AR handshake in cycle N makes rvalid=1 in cycle N+1; the burst then runs 1 beat/cycle while rready=1.
REQ-024 While rvalid=1 and rready=0, rdata/rresp/rlast/rid SHALL hold stable.
REQ-025 rlast SHALL be 1 exactly on beat index == captured arlen.
REQ-026 Write FSM: W_IDLE (awready=1) -> W_DATA (wready=1) -> W_RESP (bvalid=1) -> W_IDLE on bready.
REQ-027 W_DATA: each wvalid&wready beat writes the bytes enabled by wstrb; when the beat count reaches awlen the FSM goes to W_RESP.
REQ-028 A wlast value that disagrees with the beat count (early, or missing on the final beat) SHALL set bresp=SLVERR; all beats are still written.
REQ-029 Beat address: FIXED repeats the start address; INCR adds 1<<size; word index wraps modulo array size.
REQ-030 The read and write FSMs SHALL run concurrently; a write beat committed in cycle N is visible to read data registered in cycle N+1 or later.
REQ-031 A new AR or AW is accepted in the cycle its FSM returns to idle at the earliest; no outstanding-transaction queue.

Reset
REQ-032 While reset=1: arready=awready=0, and rvalid, rlast, wready, bvalid, rresp, bresp, rid, bid, rdata are all 0; both FSMs are forced to idle, including mid-burst.
REQ-033 Reset SHALL NOT clear the memory array; arready=awready=1 from the first clock edge after reset falls.

Configuration
REQ-034 Macro AXI_SRAM_SLAVE_WRAP_EN defined: WRAP bursts wrap within an aligned (len+1)*(1<<size) byte window, with an OKAY response.
REQ-035 Macro undefined: a WRAP burst gets SLVERR on every read beat with rdata=0, its write beats are discarded, and bresp=SLVERR; beat counts and handshakes are unchanged.

Verification
REQ-036 INCR write awaddr=0x100, awlen=3, wdata 0x11..0x44, wstrb=F, then INCR read of the same range -> rdata 0x11,0x22,0x33,0x44; rlast on beat 3; bresp=rresp=OKAY.
REQ-037 Read with rready toggled every cycle -> rdata held stable while stalled; 4 beats delivered in order; rid equals arid=0xA.
REQ-038 Single write 0xAABBCCDD with wstrb=0101 over 0 -> readback 0x00BB00DD.
REQ-039 awlen=1 with wlast asserted on beat 0 -> bresp=SLVERR, 2 beats written, bvalid held until bready.
REQ-040 WRAP read araddr=0x108, len=3, size=2 -> addresses 0x108,0x10C,0x100,0x104 with macro defined; SLVERR on all beats with macro undefined.
REQ-041 Assert reset during beat 2 of an 8-beat read -> rvalid=0 immediately; after release, arready=1 and a new burst completes normally.
